// File: rtl/async_fifo_4x4_pkg.sv
// ============================================================================
// async_fifo_4x4_pkg : shared defaults and types for the 4x4 single-clock FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

package async_fifo_4x4_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_DEPTH  = 4;
  localparam int unsigned DEF_ADDR_W = $clog2(DEF_DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  typedef logic [DEF_ADDR_W:0]   ptr_t;
  typedef logic [DEF_DATA_W-1:0] data_t;

endpackage

`default_nettype wire

// File: rtl/async_fifo_4x4_mem.sv
// ============================================================================
// async_fifo_4x4_mem : DEPTH x DATA_W register file, sync write, registered read
// Revision: 1.0
// ============================================================================
`default_nettype none

module async_fifo_4x4_mem
  import async_fifo_4x4_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]          rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Read samples the pre-edge array, so a same-edge write to the read slot is not seen.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Storage is deliberately not reset; only the output register is.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/async_fifo_4x4.sv
// ============================================================================
// async_fifo_4x4 : 4-entry x 4-bit single-clock FIFO with registered read data.
// Optional sticky overflow/underflow outputs: ASYNC_FIFO_4X4_ERR_FLAGS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module async_fifo_4x4
  import async_fifo_4x4_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
`ifdef ASYNC_FIFO_4X4_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [ADDR_W:0] wr_ptr_q;
  logic [ADDR_W:0] wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q;
  logic [ADDR_W:0] rd_ptr_d;
  logic            wr_fire;
  logic            rd_fire;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  // Each side is gated only by its own flag, so full+both reads and empty+both writes.
  assign wr_fire = wr_en && !full  && !rst;
  assign rd_fire = rd_en && !empty && !rst;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  async_fifo_4x4_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_data (din),
    .rd_en   (rd_fire),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_data (dout)
  );

`ifdef ASYNC_FIFO_4X4_ERR_FLAGS_EN
  logic overflow_q;
  logic overflow_d;
  logic underflow_q;
  logic underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (wr_en & full);
    underflow_d = underflow_q | (rd_en & empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_async_fifo_4x4.sv
// ============================================================================
// tb_async_fifo_4x4 : self-checking bench, queue-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_async_fifo_4x4;
  import async_fifo_4x4_pkg::*;

  localparam int CAP = 4;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  wr_en = 1'b0;
  logic  rd_en = 1'b0;
  data_t din = '0;
  data_t dout;
  logic  full;
  logic  empty;
`ifdef ASYNC_FIFO_4X4_ERR_FLAGS_EN
  logic  overflow;
  logic  underflow;
`endif

  async_fifo_4x4 dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
`ifdef ASYNC_FIFO_4X4_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, plus last-read value and sticky errors.
  data_t q[$];
  data_t dout_m = '0;
  logic  ov_m = 1'b0;
  logic  un_m = 1'b0;
  int    n_vec = 0;
  int    n_err = 0;

  // Apply one clock of stimulus and advance the model by the FIFO rules.
  task automatic cycle(input logic w, input logic r, input data_t d);
    int pre;
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    pre = q.size();
    if (rst) begin
      q.delete();
      dout_m = '0;
      ov_m   = 1'b0;
      un_m   = 1'b0;
    end else begin
      if (w && pre == CAP) ov_m = 1'b1;
      if (r && pre == 0)   un_m = 1'b1;
      if (r && pre > 0)    dout_m = q.pop_front();
      if (w && pre < CAP)  q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, '0);
      n_vec++;
      if ({dout, full, empty} !== {4'h0, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL reset[%0d]: dout/full/empty=%h/%b/%b required 0/0/1", i, dout, full, empty);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    data_t vals [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, vals[i]);
      n_vec++;
      if ({dout, full, empty} !== {dout_m, q.size() == CAP, q.size() == 0}) begin
        n_err++;
        $display("FAIL fill[%0d]: dout/full/empty=%h/%b/%b required %h/%b/%b",
                 i, dout, full, empty, dout_m, q.size() == CAP, q.size() == 0);
      end
    end
    n_vec++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      n_err++;
      $display("FAIL fill_flags: full/empty=%b/%b required 1/0", full, empty);
    end
  endtask

  task automatic test_drain();
    data_t want [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hD};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, '0);
      n_vec++;
      if (dout !== want[i] || dout !== dout_m) begin
        n_err++;
        $display("FAIL drain[%0d]: dout=%h required %h", i, dout, want[i]);
      end
      n_vec++;
      if (empty !== (i >= 3) || full !== 1'b0) begin
        n_err++;
        $display("FAIL drain_flags[%0d]: full/empty=%b/%b required 0/%b", i, full, empty, i >= 3);
      end
    end
  endtask

  task automatic test_interleave();
    int plan_n [4] = '{2, 1, 3, 4};
    bit plan_w [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < plan_n[s]; k++) begin
        cycle(plan_w[s], !plan_w[s], data_t'($urandom_range(0, 15)));
        n_vec++;
        if ({dout, full, empty} !== {dout_m, q.size() == CAP, q.size() == 0}) begin
          n_err++;
          $display("FAIL interleave[%0d.%0d]: dout/full/empty=%h/%b/%b required %h/%b/%b",
                   s, k, dout, full, empty, dout_m, q.size() == CAP, q.size() == 0);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int occ;
    cycle(1'b1, 1'b0, 4'h3);
    cycle(1'b1, 1'b0, 4'h5);
    occ = q.size();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, data_t'($urandom_range(0, 15)));
      n_vec++;
      if ({dout, full, empty} !== {dout_m, 1'b0, 1'b0} || q.size() != occ) begin
        n_err++;
        $display("FAIL simul_mid[%0d]: dout/full/empty=%h/%b/%b required %h/0/0", i, dout, full, empty, dout_m);
      end
    end
    while (q.size() < CAP) cycle(1'b1, 1'b0, data_t'($urandom_range(0, 15)));
    cycle(1'b1, 1'b1, 4'h9);
    n_vec++;
    if ({dout, full, empty} !== {dout_m, 1'b0, 1'b0} || q.size() != CAP - 1) begin
      n_err++;
      $display("FAIL simul_full: dout/full/empty=%h/%b/%b required %h/0/0", dout, full, empty, dout_m);
    end
    while (q.size() > 0) cycle(1'b0, 1'b1, '0);
    cycle(1'b1, 1'b1, 4'h6);
    n_vec++;
    if ({dout, full, empty} !== {dout_m, 1'b0, 1'b0} || q.size() != 1) begin
      n_err++;
      $display("FAIL simul_empty: dout/full/empty=%h/%b/%b required %h/0/0", dout, full, empty, dout_m);
    end
    cycle(1'b0, 1'b1, '0);
    n_vec++;
    if (dout !== 4'h6 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL simul_empty_rd: dout/empty=%h/%b required 6/1", dout, empty);
    end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, data_t'(i + 7));
`ifdef ASYNC_FIFO_4X4_ERR_FLAGS_EN
    n_vec++;
    if ({overflow, underflow} !== {ov_m, un_m}) begin
      n_err++;
      $display("FAIL err_before_rst: ovf/unf=%b/%b required %b/%b", overflow, underflow, ov_m, un_m);
    end
`endif
    rst = 1'b1;
    cycle(1'b1, 1'b1, 4'hF);
    rst = 1'b0;
    n_vec++;
    if ({dout, full, empty} !== {4'h0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL midop_rst: dout/full/empty=%h/%b/%b required 0/0/1", dout, full, empty);
    end
`ifdef ASYNC_FIFO_4X4_ERR_FLAGS_EN
    n_vec++;
    if ({overflow, underflow} !== 2'b00) begin
      n_err++;
      $display("FAIL err_after_rst: ovf/unf=%b/%b required 0/0", overflow, underflow);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      cycle(1'($urandom), 1'($urandom), data_t'($urandom));
      rst = 1'b0;
      n_vec++;
      if ({dout, full, empty} !== {dout_m, q.size() == CAP, q.size() == 0}) begin
        n_err++;
        $display("FAIL random[%0d]: dout/full/empty=%h/%b/%b required %h/%b/%b",
                 i, dout, full, empty, dout_m, q.size() == CAP, q.size() == 0);
      end
`ifdef ASYNC_FIFO_4X4_ERR_FLAGS_EN
      n_vec++;
      if ({overflow, underflow} !== {ov_m, un_m}) begin
        n_err++;
        $display("FAIL random_err[%0d]: ovf/unf=%b/%b required %b/%b", i, overflow, underflow, ov_m, un_m);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_interleave();
    test_simultaneous();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
